fp16_accumulator: RTL and testbench
===================================

// Module: fp16_accumulator
// PURPOSE
//  Serial FP16 adder-accumulator for the Softmax datapath.
//  - Sums a stream of FP16 values, typically exp(x_i), into one FP16 denominator with an element count.
//  - Its result feeds the reciprocal stage, whose output becomes an operand of fp16_multiplier.
//  - Multi-cycle FSM; valid/ready handshake on both input and output.
// PARAMETERS
//  MAX_LEN  64                       maximum elements per stream; element number MAX_LEN is treated as last
//  CNT_W    $clog2(MAX_LEN+1)        width of sum_count (derived; do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  reset_b    in   1      asynchronous active-low reset
//  clear      in   1      synchronous abort/flush, highest priority
//  in_valid   in   1      in_data/in_last valid
//  in_ready   out  1      accumulator can take an element
//  in_data    in   16     FP16 operand {sign, exp[4:0], man[9:0]}
//  in_last    in   1      final element of the stream
//  sum_valid  out  1      sum_data/sum_count valid
//  sum_ready  in   1      downstream accepts the sum
//  sum_data   out  16     FP16 accumulated sum
//  sum_count  out  CNT_W  number of elements summed
//  overflow   out  1      sticky; sum saturated to +/-Inf or an operand was Inf/NaN
// BEHAVIOUR
//  Reset: state=IDLE, acc=16'h0000, count=0. All outputs are 0, including in_ready.
//   in_ready rises in the first cycle after reset_b deasserts. in_ready is a registered output.
//  FSM:
//   IDLE  : in_ready=1. On in_valid&in_ready, latch operand and last flag, count+=1, go to ALIGN.
//   ALIGN : Compare exponents; swap so the larger operand is first.
//           Right-shift the smaller 11b significand (hidden bit included) into 14b,
//           keeping guard, round and sticky bits.
//   NORM  : Add or subtract by sign, then normalise with a leading-zero shift.
//           Round to nearest, ties to even. Write acc.
//           Next state is DONE if last was latched or count==MAX_LEN; otherwise IDLE.
//   DONE  : sum_valid=1, with sum_data and sum_count held stable.
//           On sum_ready: acc=0, count=0, overflow=0, go to IDLE.
//  Throughput and latency:
//   - At most one element per 3 cycles.
//   - sum_valid asserts exactly 3 cycles after the edge that accepts the last element.
//  Arithmetic:
//   - Exact cancellation gives +0.
//   - Exponent difference >13 leaves the smaller operand contributing only sticky.
//   - Exponent result >30 saturates to sign|0x7C00 and sets overflow.
//   - An Inf or NaN input (exp==31) sets overflow; acc becomes 0x7E00, which then persists.
//   - Exponent underflow flushes to +0.
//  clear:
//   - Acts in any state: next state IDLE, acc=0, count=0, overflow=0.
//   - sum_valid drops and in_ready is 0 in that cycle.
//   - An input offered in the same cycle as clear is not accepted.
//  Backpressure: in DONE, in_ready=0 and outputs are frozen until sum_ready. No internal timeout.
//  Zero inputs still increment count; acc is unchanged.
// CONFIGURATION
//  FP16_ACC_SUBNORM_EN
//   Defined:   exp==0 inputs are treated as subnormals (hidden bit 0, exponent 1).
//              Results below 2^-14 are emitted as subnormals.
//   Undefined: subnormal inputs and results flush to +0, matching fp16_multiplier.
// STRUCTURE
//  softmax_fp16_pkg:
//   - constants FP16_BIAS=15, FP16_EXP_MAX=31, FP16_POS_INF=16'h7C00, FP16_QNAN=16'h7E00
//   - typedef acc_state_t {IDLE, ALIGN, NORM, DONE}
//  Sub-module fp16_align_shift: combinational 14b right shifter with sticky OR of the shifted-out bits.
//  Registers: acc, operand, state, count, flags. No further hierarchy.
// TESTING
//  1. Four elements 0x3C00, last on the 4th -> sum_data=0x4400, sum_count=4, overflow=0.
//  2. 0x3C00 then 0xBC00(last) -> sum_data=0x0000 (positive zero), sum_count=2.
//  3. 0x7BFF then 0x7BFF(last) -> sum_data=0x7C00, overflow=1. After sum_ready, overflow reads 0.
//  4. Rounding:
//     - 0x3C00 + 0x1000 (2^-11, a tie) -> 0x3C00.
//     - 0x3C00 + 0x1400 -> 0x3C01.
//     - 0x3C01 + 0x1000 -> 0x3C02 (tie, round to even).
//  5. Assert clear during ALIGN of the 3rd element, then send 0x4000(last).
//     -> sum_data=0x4000, sum_count=1, with no residue from the aborted stream.
//  6. MAX_LEN=4 with five 0x3C00 inputs and no in_last, plus sum_ready held low for 5 cycles.
//     -> sum 0x4400, count 4, stable while stalled, in_ready=0.
//     -> The 5th element is accepted only after the handshake.
//  Also: reset_b asserted mid-NORM -> all outputs 0 immediately; in_ready=1 the cycle after release.

Source files
------------

// File: rtl/softmax_fp16_pkg.sv
// FP16 constants, accumulator state type and operand unpacking for the softmax datapath.
// Operand decoding depends on FP16_ACC_SUBNORM_EN (subnormal support vs flush-to-zero).
package softmax_fp16_pkg;

   localparam int          FP16_BIAS    = 15;
   localparam int          FP16_EXP_MAX = 31;
   localparam logic [15:0] FP16_POS_INF = 16'h7C00;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam int          ALIGN_W      = 14;

   typedef enum logic [1:0] {IDLE, ALIGN, NORM, DONE} acc_state_t;

   typedef struct packed {
      logic        sign;
      logic [4:0]  exp;
      logic [10:0] sig;
      logic        is_zero;
      logic        is_special;
   } fp16_fields_t;

   // Effective exponent and significand with the hidden bit made explicit.
   function automatic fp16_fields_t fp16_unpack(input logic [15:0] v);
      fp16_fields_t f;
      f.sign       = v[15];
      f.is_special = (v[14:10] == 5'(FP16_EXP_MAX));
`ifdef FP16_ACC_SUBNORM_EN
      f.is_zero    = (v[14:0] == 15'd0);
      f.exp        = (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
      f.sig        = {(v[14:10] != 5'd0), v[9:0]};
`else
      f.is_zero    = (v[14:10] == 5'd0);
      f.exp        = v[14:10];
      f.sig        = f.is_zero ? 11'd0 : {1'b1, v[9:0]};
`endif
      return f;
   endfunction

   function automatic logic [3:0] lzc14(input logic [13:0] v);
      logic [3:0] n;
      logic       found;
      n     = 4'd14;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 4'(13 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fp16_align_shift.sv
// Right shifter for the smaller significand; bits shifted out are OR-ed into the LSB (sticky).
module fp16_align_shift
   import softmax_fp16_pkg::*;
(
   input  logic [ALIGN_W-1:0] data,
   input  logic [4:0]         shamt,
   output logic [ALIGN_W-1:0] shifted
);

   logic [ALIGN_W-1:0] base;
   logic [ALIGN_W-1:0] mask;

   always_comb begin
      if (shamt >= 5'(ALIGN_W)) begin
         base = '0;
         mask = '1;
      end else begin
         base = data >> shamt;
         mask = (ALIGN_W'(1) << shamt) - ALIGN_W'(1);
      end
      shifted = {base[ALIGN_W-1:1], base[0] | (|(data & mask))};
   end

endmodule

// File: rtl/fp16_accumulator.sv
// Serial FP16 adder-accumulator producing a softmax denominator and element count.
// Define FP16_ACC_SUBNORM_EN to keep subnormal inputs/results instead of flushing them to +0.
//
// state | meaning
// IDLE  | in_ready high, waiting for an element
// ALIGN | order operands by magnitude, align the smaller significand
// NORM  | add/subtract, normalise, round, write acc
// DONE  | sum_valid high, outputs frozen until sum_ready
module fp16_accumulator
   import softmax_fp16_pkg::*;
#(
   parameter  int MAX_LEN = 64,
   localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [15:0]      sum_data,
   output logic [CNT_W-1:0] sum_count,
   output logic             overflow
);

   acc_state_t       state;
   logic [15:0]      acc;
   logic [15:0]      opnd;
   logic             last_q;
   logic [CNT_W-1:0] count;

   logic [13:0] big_q, small_q;
   logic [4:0]  exp_q;
   logic        sign_q, sub_q;
   logic        bypass_q, bypass_ovf_q;
   logic [15:0] bypass_val_q;

   fp16_fields_t ua, ub;
   logic         a_big;
   logic [10:0]  big_sig, small_sig;
   logic [4:0]   big_exp, small_exp, shamt;
   logic         big_sign;
   logic [13:0]  small_al;
   logic         bypass;
   logic         bypass_ovf;
   logic [15:0]  bypass_val;

   always_comb begin
      ua        = fp16_unpack(acc);
      ub        = fp16_unpack(opnd);
      a_big     = (ua.exp > ub.exp) || ((ua.exp == ub.exp) && (ua.sig >= ub.sig));
      big_sig   = a_big ? ua.sig  : ub.sig;
      big_exp   = a_big ? ua.exp  : ub.exp;
      big_sign  = a_big ? ua.sign : ub.sign;
      small_sig = a_big ? ub.sig  : ua.sig;
      small_exp = a_big ? ub.exp  : ua.exp;
      shamt     = big_exp - small_exp;

      // Specials and zero operands skip the adder so they come out bit-exact.
      bypass     = 1'b1;
      bypass_ovf = 1'b0;
      bypass_val = acc;
      if (ub.is_special) begin
         bypass_val = FP16_QNAN;
         bypass_ovf = 1'b1;
      end else if (ua.is_special || ub.is_zero) begin
         bypass_val = acc;
      end else if (ua.is_zero) begin
         bypass_val = opnd;
      end else begin
         bypass = 1'b0;
      end
   end

   fp16_align_shift u_align_shift (
      .data    ({small_sig, 3'b000}),
      .shamt   (shamt),
      .shifted (small_al)
   );

   logic [14:0] sum15;
   logic [3:0]  lz;
   logic [4:0]  sh;
   logic [13:0] norm_sig;
   logic [5:0]  norm_exp, exp_field;
   logic        uflow, rnd_up, arith_ovf;
   logic [15:0] rounded, arith_res;

   always_comb begin
      sum15    = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
      lz       = lzc14(sum15[13:0]);
      sh       = '0;
      uflow    = 1'b0;
      norm_sig = '0;
      norm_exp = '0;
      if (sum15[14]) begin
         norm_sig = {sum15[14:2], sum15[1] | sum15[0]};
         norm_exp = {1'b0, exp_q} + 6'd1;
      end else begin
`ifdef FP16_ACC_SUBNORM_EN
         sh = ({1'b0, lz} >= exp_q) ? (exp_q - 5'd1) : {1'b0, lz};
`else
         sh    = {1'b0, lz};
         uflow = ({1'b0, lz} >= exp_q);
`endif
         norm_sig = sum15[13:0] << sh;
         norm_exp = {1'b0, exp_q} - {1'b0, sh};
      end
      exp_field = norm_sig[13] ? norm_exp : 6'd0;
      rnd_up    = norm_sig[2] & (norm_sig[3] | norm_sig[1] | norm_sig[0]);
      // A mantissa carry from rounding ripples straight into the exponent field.
      rounded   = {exp_field, norm_sig[12:3]} + 16'(rnd_up);
      arith_ovf = 1'b0;
      if ((sum15 == 15'd0) || uflow) begin
         arith_res = '0;
      end else if (rounded[15:10] >= 6'(FP16_EXP_MAX)) begin
         arith_res = {sign_q, FP16_POS_INF[14:0]};
         arith_ovf = 1'b1;
      end else begin
         arith_res = {sign_q, rounded[14:0]};
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state        <= IDLE;
         acc          <= '0;
         opnd         <= '0;
         last_q       <= 1'b0;
         count        <= '0;
         overflow     <= 1'b0;
         in_ready     <= 1'b0;
         sum_valid    <= 1'b0;
         big_q        <= '0;
         small_q      <= '0;
         exp_q        <= '0;
         sign_q       <= 1'b0;
         sub_q        <= 1'b0;
         bypass_q     <= 1'b0;
         bypass_ovf_q <= 1'b0;
         bypass_val_q <= '0;
      end else if (clear) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         last_q    <= 1'b0;
         in_ready  <= 1'b0;
         sum_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_ready && in_valid) begin
                  opnd     <= in_data;
                  last_q   <= in_last;
                  count    <= count + CNT_W'(1);
                  in_ready <= 1'b0;
                  state    <= ALIGN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ALIGN: begin
               big_q        <= {big_sig, 3'b000};
               small_q      <= small_al;
               exp_q        <= big_exp;
               sign_q       <= big_sign;
               sub_q        <= ua.sign ^ ub.sign;
               bypass_q     <= bypass;
               bypass_ovf_q <= bypass_ovf;
               bypass_val_q <= bypass_val;
               state        <= NORM;
            end
            NORM: begin
               acc      <= bypass_q ? bypass_val_q : arith_res;
               overflow <= overflow | (bypass_q ? bypass_ovf_q : arith_ovf);
               if (last_q || (count == CNT_W'(MAX_LEN))) begin
                  sum_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            DONE: begin
               if (sum_ready) begin
                  sum_valid <= 1'b0;
                  acc       <= '0;
                  count     <= '0;
                  overflow  <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sum_data  = acc;
   assign sum_count = count;

endmodule

// File: tb/tb_fp16_accumulator.sv
// Scoreboard bench for fp16_accumulator built with MAX_LEN=4 so the length limit is reachable.
module tb_fp16_accumulator;
   import softmax_fp16_pkg::*;

   localparam int          MAX_LEN = 4;
   localparam int          CNT_W   = $clog2(MAX_LEN + 1);
   localparam logic [15:0] ONE     = {1'b0, 5'(FP16_BIAS), 10'd0};

   logic             clk = 1'b0, reset_b = 1'b0, clear = 1'b0;
   logic             in_valid = 1'b0, in_last = 1'b0, sum_ready = 1'b0;
   logic [15:0]      in_data = '0;
   logic             in_ready, sum_valid, overflow;
   logic [15:0]      sum_data;
   logic [CNT_W-1:0] sum_count;

   typedef struct {
      logic [15:0]      data;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   fp16_accumulator #(.MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .sum_data  (sum_data),
      .sum_count (sum_count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [15:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_sum(output int cycles);
      cycles = 0;
      while (!sum_valid && cycles < 50) begin
         @(posedge clk); #1;
         cycles++;
      end
      checks++;
      if (sum_valid !== 1'b1) begin
         errors++;
         $display("FAIL sum_timeout sum_valid=%b required=1", sum_valid);
      end
   endtask

   task automatic ack();
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({in_ready, sum_valid, sum_data, sum_count, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b vld=%b data=%h cnt=%0d ovf=%b want all 0",
                  in_ready, sum_valid, sum_data, sum_count, overflow);
      end
      @(negedge clk);
      reset_b = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_cycle_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_sum_basic();
      exp_t e;
      int   cyc;
      sb.push_back('{16'h4400, CNT_W'(4), 1'b0});
      for (int i = 0; i < 4; i++) send(ONE, i == 3);
      wait_sum(cyc);
      // sum_valid must be up in the third cycle following the accepting edge.
      checks++;
      if (cyc != 2) begin
         errors++;
         $display("FAIL basic_latency got %0d extra edges want 2", cyc);
      end
      e = sb.pop_front();
      checks++;
      if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
         errors++;
         $display("FAIL basic_sum got %h/%0d/%b want %h/%0d/%b",
                  sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
      end
      ack();
      checks++;
      if ({sum_valid, in_ready, sum_count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
         errors++;
         $display("FAIL basic_after_ack got vld=%b rdy=%b cnt=%0d want 0/1/0",
                  sum_valid, in_ready, sum_count);
      end
   endtask

   task automatic test_cancel();
      logic [15:0] a_op [3];
      logic [15:0] b_op [3];
      logic [15:0] res  [3];
      exp_t        e;
      int          cyc;
      a_op = '{ONE,      16'h4200, ONE};
      b_op = '{16'hBC00, 16'hBC00, 16'hC200};
      res  = '{16'h0000, 16'h4000, 16'hC000};
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{res[i], CNT_W'(2), 1'b0});
         send(a_op[i], 1'b0);
         send(b_op[i], 1'b1);
         wait_sum(cyc);
         e = sb.pop_front();
         checks++;
         if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
            errors++;
            $display("FAIL cancel_%0d got %h/%0d/%b want %h/%0d/%b",
                     i, sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
         end
         ack();
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      int   cyc;
      sb.push_back('{16'h7C00, CNT_W'(2), 1'b1});
      send(16'h7BFF, 1'b0);
      send(16'h7BFF, 1'b1);
      wait_sum(cyc);
      e = sb.pop_front();
      checks++;
      if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
         errors++;
         $display("FAIL ovf_saturate got %h/%0d/%b want %h/%0d/%b",
                  sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
      end
      ack();
      checks++;
      if ({overflow, sum_data} !== {1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL ovf_cleared got ovf=%b data=%h want 0/0000", overflow, sum_data);
      end
      sb.push_back('{16'h7E00, CNT_W'(2), 1'b1});
      send(16'h7C00, 1'b0);
      send(ONE, 1'b1);
      wait_sum(cyc);
      e = sb.pop_front();
      checks++;
      if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
         errors++;
         $display("FAIL ovf_nan got %h/%0d/%b want %h/%0d/%b",
                  sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
      end
      ack();
   endtask

   task automatic test_rounding();
      logic [15:0] a_op [3];
      logic [15:0] b_op [3];
      logic [15:0] res  [3];
      exp_t        e;
      int          cyc;
      a_op = '{ONE,      ONE,      16'h3C01};
      b_op = '{16'h1000, 16'h1400, 16'h1000};
      res  = '{16'h3C00, 16'h3C01, 16'h3C02};
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{res[i], CNT_W'(2), 1'b0});
         send(a_op[i], 1'b0);
         send(b_op[i], 1'b1);
         wait_sum(cyc);
         e = sb.pop_front();
         checks++;
         if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
            errors++;
            $display("FAIL round_%0d got %h/%0d/%b want %h/%0d/%b",
                     i, sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
         end
         ack();
      end
   endtask

   task automatic test_clear();
      exp_t e;
      int   cyc;
      in_valid = 1'b1;
      in_data  = ONE;
      clear    = 1'b1;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({sum_count, in_ready} !== {CNT_W'(0), 1'b0}) begin
         errors++;
         $display("FAIL clear_blocks_input got cnt=%0d rdy=%b want 0/0", sum_count, in_ready);
      end
      for (int i = 0; i < 3; i++) send(ONE, 1'b0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checks++;
      if ({sum_valid, in_ready, sum_data, sum_count, overflow} !== '0) begin
         errors++;
         $display("FAIL clear_in_align got vld=%b rdy=%b data=%h cnt=%0d ovf=%b want all 0",
                  sum_valid, in_ready, sum_data, sum_count, overflow);
      end
      sb.push_back('{16'h4000, CNT_W'(1), 1'b0});
      send(16'h4000, 1'b1);
      wait_sum(cyc);
      e = sb.pop_front();
      checks++;
      if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
         errors++;
         $display("FAIL clear_restart got %h/%0d/%b want %h/%0d/%b",
                  sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
      end
      ack();
      send(ONE, 1'b1);
      wait_sum(cyc);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checks++;
      if ({sum_valid, sum_data} !== {1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL clear_in_done got vld=%b data=%h want 0/0000", sum_valid, sum_data);
      end
   endtask

   task automatic test_max_len_backpressure();
      exp_t e;
      int   cyc;
      sb.push_back('{16'h4400, CNT_W'(4), 1'b0});
      for (int i = 0; i < 4; i++) send(ONE, 1'b0);
      in_valid = 1'b1;
      in_data  = ONE;
      in_last  = 1'b0;
      wait_sum(cyc);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({sum_valid, in_ready, sum_data, sum_count} !== {1'b1, 1'b0, 16'h4400, CNT_W'(4)}) begin
            errors++;
            $display("FAIL stall_%0d got vld=%b rdy=%b data=%h cnt=%0d want 1/0/4400/4",
                     i, sum_valid, in_ready, sum_data, sum_count);
         end
         @(posedge clk); #1;
      end
      e = sb.pop_front();
      checks++;
      if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
         errors++;
         $display("FAIL maxlen_sum got %h/%0d/%b want %h/%0d/%b",
                  sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
      end
      ack();
      checks++;
      if ({in_ready, sum_count} !== {1'b1, CNT_W'(0)}) begin
         errors++;
         $display("FAIL maxlen_after_ack got rdy=%b cnt=%0d want 1/0", in_ready, sum_count);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({in_ready, sum_count} !== {1'b0, CNT_W'(1)}) begin
         errors++;
         $display("FAIL maxlen_fifth_taken got rdy=%b cnt=%0d want 0/1", in_ready, sum_count);
      end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic test_reset_mid_norm();
      exp_t e;
      int   cyc;
      send(ONE, 1'b0);
      send(ONE, 1'b0);
      @(posedge clk); #1;
      #2 reset_b = 1'b0;
      #1;
      checks++;
      if ({in_ready, sum_valid, sum_data, sum_count, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_mid_norm got rdy=%b vld=%b data=%h cnt=%0d ovf=%b want all 0",
                  in_ready, sum_valid, sum_data, sum_count, overflow);
      end
      @(negedge clk);
      reset_b = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_norm_ready got %b want 1", in_ready);
      end
      sb.push_back('{ONE, CNT_W'(1), 1'b0});
      send(ONE, 1'b1);
      wait_sum(cyc);
      e = sb.pop_front();
      checks++;
      if ({sum_data, sum_count, overflow} !== {e.data, e.cnt, e.ovf}) begin
         errors++;
         $display("FAIL post_reset_sum got %h/%0d/%b want %h/%0d/%b",
                  sum_data, sum_count, overflow, e.data, e.cnt, e.ovf);
      end
      ack();
   endtask

   initial begin
      test_reset();
      test_sum_basic();
      test_cancel();
      test_overflow();
      test_rounding();
      test_clear();
      test_max_len_backpressure();
      test_reset_mid_norm();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
